// File: rtl/mem_bank_ctrl.sv
// mem_bank_ctrl: 4-bank interleaved 16-bit word store with per-bank busy timers and a 2-stage read pipe.
// Optional BANK_CONFLICT_ERR_EN additionally raises err on a bank-conflict stall.
module mem_bank_ctrl #(
    parameter int ADDR_BITS = 16,
    parameter int BANK_BUSY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        rd_valid,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);
    logic [15:0] mem [2**(ADDR_BITS-1)];
    logic [2:0] cnt [4];
    logic [ADDR_BITS-2:0] idx;
    logic [1:0] bank;
    logic [15:0] s1_d;
    logic req, legal, acc, s1_v;
    assign idx = addr[ADDR_BITS-1:1];
    assign bank = addr[2:1];
    assign req = rd ^ wr;
    assign legal = req & ~addr[0];
    assign stall = legal & busy[bank];
    assign acc = legal & ~busy[bank];
`ifdef BANK_CONFLICT_ERR_EN
    assign err = (rd & wr) | (req & addr[0]) | stall;
`else
    assign err = (rd & wr) | (req & addr[0]);
`endif
    for (genvar i = 0; i < 4; i++) begin : g_busy
        assign busy[i] = |cnt[i];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            s1_v <= 1'b0;
            s1_d <= '0;
            rd_valid <= 1'b0;
            data_out <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                cnt[i] <= (acc && bank == 2'(i)) ? 3'(BANK_BUSY - 1) : cnt[i] - 3'(busy[i]);
            s1_v <= acc & rd;
            s1_d <= (acc & rd) ? mem[idx] : '0;
            rd_valid <= s1_v;
            data_out <= s1_d;
        end
    end
    // Array is never cleared by reset; writes are simply suppressed while it is held.
    always_ff @(posedge clk) begin
        if (acc & wr & ~rst) mem[idx] <= data_in;
    end
endmodule

// File: tb/tb_mem_bank_ctrl.sv
// tb_mem_bank_ctrl: directed plus random stimulus against a cycle-level model of bank timing and read latency.
module tb_mem_bank_ctrl;
    localparam int BB = 4;
`ifdef BANK_CONFLICT_ERR_EN
    localparam logic CE = 1'b1;
`else
    localparam logic CE = 1'b0;
`endif
    logic clk = 0, rst = 1, rd = 0, wr = 0;
    logic [15:0] addr = 0, data_in = 0, data_out;
    logic rd_valid, stall, err;
    logic [3:0] busy;

    mem_bank_ctrl #(.ADDR_BITS(16), .BANK_BUSY(BB)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd(rd), .wr(wr),
        .data_out(data_out), .rd_valid(rd_valid), .stall(stall), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [15:0] d; } rd_t;
    rd_t q[$];
    logic [15:0] mm [32];
    int free_at [4];
    int cyc = 0, checks = 0, errors = 0;
    logic [15:0] o_data;
    logic o_valid, o_stall, o_err;
    logic [3:0] o_busy;

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Model: a bank is busy while cyc < accept_cycle + BANK_BUSY; reads return at accept_cycle + 2.
    task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d, input logic rs);
        logic legal, e_stall, e_err, e_v;
        logic [3:0] eb;
        logic [15:0] e_d;
        int b;
        @(negedge clk);
        rd = r; wr = w; addr = a; data_in = d; rst = rs;
        #1;
        if (rs) begin
            q.delete();
            for (int i = 0; i < 4; i++) free_at[i] = 0;
        end
        b = int'(a[2:1]);
        for (int i = 0; i < 4; i++) eb[i] = !rs && cyc < free_at[i];
        legal = (r ^ w) && !a[0];
        e_stall = legal && eb[b];
        e_err = (r && w) || ((r ^ w) && a[0]) || (CE && e_stall);
        e_v = q.size() > 0 && q[0].due == cyc;
        e_d = e_v ? q[0].d : 16'h0;
        o_data = data_out; o_valid = rd_valid; o_stall = stall; o_err = err; o_busy = busy;
        chk("stall", {15'b0, stall}, {15'b0, e_stall});
        chk("err", {15'b0, err}, {15'b0, e_err});
        chk("busy", {12'b0, busy}, {12'b0, eb});
        chk("rd_valid", {15'b0, rd_valid}, {15'b0, e_v});
        chk("data_out", data_out, e_d);
        if (e_v) void'(q.pop_front());
        if (!rs && legal && !eb[b]) begin
            free_at[b] = cyc + BB;
            if (r) q.push_back('{cyc + 2, mm[a[5:1]]});
            else mm[a[5:1]] = d;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 16'h0, 0);
    endtask

    initial begin
        int op;
        logic [15:0] ra;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_busy", {12'b0, o_busy}, 16'h0);
        chk("reset_valid", {15'b0, o_valid}, 16'h0);
        // preload: rotating banks 0..3 never conflicts at BANK_BUSY=4
        for (int i = 0; i < 32; i++) step(0, 1, 16'(2 * i), 16'($urandom), 0);
        idle(4);
        // single write then read
        step(0, 1, 16'h0010, 16'hBEEF, 0);
        idle(4);
        step(1, 0, 16'h0010, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("beef_n1_valid", {15'b0, o_valid}, 16'h0);
        step(0, 0, 0, 0, 0);
        chk("beef_valid", {15'b0, o_valid}, 16'h1);
        chk("beef_data", o_data, 16'hBEEF);
        step(0, 0, 0, 0, 0);
        chk("beef_n3_valid", {15'b0, o_valid}, 16'h0);
        idle(4);
        // four banks back to back
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 16'(2 * i), 0, 0);
            chk("b2b_stall", {15'b0, o_stall}, 16'h0);
        end
        for (int i = 0; i < 2; i++) begin
            chk("b2b_valid", {15'b0, o_valid}, 16'h1);
            step(0, 0, 0, 0, 0);
        end
        chk("b2b_valid", {15'b0, o_valid}, 16'h1);
        idle(4);
        // same-bank conflict
        step(0, 1, 16'h0008, 16'h1234, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 16'h0008, 0, 0);
            chk("cf_stall", {15'b0, o_stall}, 16'h1);
            chk("cf_busy0", {15'b0, o_busy[0]}, 16'h1);
            chk("cf_err", {15'b0, o_err}, {15'b0, CE});
        end
        step(1, 0, 16'h0008, 0, 0);
        chk("cf_accept", {15'b0, o_stall}, 16'h0);
        idle(2);
        chk("cf_valid", {15'b0, o_valid}, 16'h1);
        chk("cf_data", o_data, 16'h1234);
        idle(4);
        // illegal requests
        step(1, 1, 16'h0020, 16'h5555, 0);
        chk("ill_both_err", {15'b0, o_err}, 16'h1);
        chk("ill_both_stall", {15'b0, o_stall}, 16'h0);
        step(1, 0, 16'h0021, 0, 0);
        chk("ill_odd_err", {15'b0, o_err}, 16'h1);
        chk("ill_odd_busy", {12'b0, o_busy}, 16'h0);
        idle(3);
        // reset discards an in-flight read and frees banks
        step(1, 0, 16'h0002, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("rst_busy", {12'b0, o_busy}, 16'h0);
        step(1, 0, 16'h0002, 0, 0);
        chk("rst_valid", {15'b0, o_valid}, 16'h0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_rd_valid", {15'b0, o_valid}, 16'h1);
        chk("rst_rd_data", o_data, mm[1]);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 9);
            ra = {10'b0, 5'($urandom_range(0, 31)), 1'b0};
            if (op == 9) ra[0] = 1'b1;
            step(op < 4 || op >= 8, (op >= 4 && op < 7) || op == 8, ra, 16'($urandom),
                 $urandom_range(0, 99) == 0);
        end
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
